fsm_period_monitor: RTL and testbench

Downstream consumer of the 10-state sequence FSM. It watches the FSM's one-cycle terminal pulse y and its present-state code ps1, and measures the number of clock cycles between successive y pulses. Measured periods are buffered in a small FIFO and drained through a valid/ready interface. A sticky flag reports any illegal state code (10..15) on ps1.

---
 rtl/fsm_period_monitor.sv | 161 ++++++++++++++++
 tb/tb_fsm_period_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_period_monitor.sv
// Measures the cycle distance between successive terminal pulses of the sequence FSM,
// buffers the periods in a first-word-fall-through FIFO and flags illegal state codes.
//
// state      | meaning
// ST_IDLE    | counter held at 0, waiting for the first pulse to arm measurement
// ST_MEASURE | counting cycles since the last pulse; each further pulse pushes a period
module fsm_period_monitor #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             y_in,
   input  logic [3:0]       ps_in,
   input  logic             clr,
   output logic [CNT_W-1:0] per_data,
   output logic             per_valid,
   input  logic             per_ready,
   output logic [LVL_W-1:0] level,
   output logic             overflow,
   output logic             sat,
   output logic             err_state
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_MEASURE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               ovf_q, ovf_d;
   logic               sat_q, sat_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   mem_q [DEPTH];

   logic               push;
   logic               pop;
   logic               full;
   logic               push_ok;

   // clr masks both FIFO ports so that it wins over any same-cycle traffic
   assign push    = (state_q == ST_MEASURE) && y_in && !clr;
   assign pop     = per_valid && per_ready && !clr;
   assign full    = (level_q == LVL_FULL);
   assign push_ok = push && (!full || pop);

   assign per_valid = (level_q != '0);
   assign per_data  = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign overflow  = ovf_q;
   assign sat       = sat_q;
   assign err_state = err_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      sat_d    = sat_q;
      err_d    = err_q;

      if (clr) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         sat_d    = 1'b0;
         err_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (y_in) begin
                  state_d = ST_MEASURE;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_MEASURE: begin
               if (y_in) begin
                  cnt_d = CNT_W'(1);
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase

         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase

         if (push && full && !pop) begin
            ovf_d = 1'b1;
         end
         if (push && (cnt_q == CNT_MAX)) begin
            sat_d = 1'b1;
         end
         if (ps_in > 4'd9) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
         err_q    <= err_d;
      end
   end

   // Storage is reset so that per_data reads 0 straight out of reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= cnt_q;
      end
   end

endmodule

// File: tb/tb_fsm_period_monitor.sv
// Directed bench for fsm_period_monitor: a pulse-timestamp model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fsm_period_monitor;

   localparam int CNT_W = 8;
   localparam int DEPTH = 4;
   localparam int LVL_W = 3;
   localparam int PMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             y_in = 1'b0;
   logic [3:0]       ps_in = 4'd0;
   logic             clr = 1'b0;
   logic [CNT_W-1:0] per_data;
   logic             per_valid;
   logic             per_ready = 1'b0;
   logic [LVL_W-1:0] level;
   logic             overflow;
   logic             sat;
   logic             err_state;

   int n_chk  = 0;
   int n_fail = 0;

   fsm_period_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .y_in      (y_in),
      .ps_in     (ps_in),
      .clr       (clr),
      .per_data  (per_data),
      .per_valid (per_valid),
      .per_ready (per_ready),
      .level     (level),
      .overflow  (overflow),
      .sat       (sat),
      .err_state (err_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a period is the edge-count distance between pulses, clipped to the counter maximum
   int  m_edge = 0;
   int  m_last = 0;
   bit  m_armed = 0;
   int  m_q[$];
   bit  m_ovf = 0;
   bit  m_sat = 0;
   bit  m_err = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_armed = 0;
         m_q.delete();
         m_ovf = 0;
         m_sat = 0;
         m_err = 0;
      end else begin
         m_edge++;
         if (clr) begin
            m_armed = 0;
            m_q.delete();
            m_ovf = 0;
            m_sat = 0;
            m_err = 0;
         end else begin
            bit do_pop;
            do_pop = (m_q.size() > 0) && per_ready;
            if (ps_in > 9) m_err = 1;
            if (y_in && m_armed) begin
               int p;
               p = m_edge - m_last;
               if (p > PMAX) p = PMAX;
               if (p == PMAX) m_sat = 1;
               if (m_q.size() < DEPTH || do_pop) begin
                  if (do_pop) void'(m_q.pop_front());
                  m_q.push_back(p);
               end else begin
                  m_ovf = 1;
               end
            end else if (do_pop) begin
               void'(m_q.pop_front());
            end
            if (y_in) begin
               m_armed = 1;
               m_last  = m_edge;
            end
         end
      end
   end

   bit run_cmp = 0;
   always @(negedge clk) begin
      if (run_cmp) begin
         chk("m_level", int'(level), m_q.size());
         chk("m_valid", int'(per_valid), int'(m_q.size() > 0));
         if (m_q.size() > 0) chk("m_data", int'(per_data), m_q[0]);
         chk("m_overflow", int'(overflow), int'(m_ovf));
         chk("m_sat", int'(sat), int'(m_sat));
         chk("m_err", int'(err_state), int'(m_err));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      y_in = 1'b1;
      @(negedge clk);
      y_in = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ps_in = 4'd3;
      cycles(2);
      chk("rst_valid", int'(per_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_data", int'(per_data), 0);
      chk("rst_flags", int'({overflow, sat, err_state}), 0);
      rst = 1'b1;
      run_cmp = 1;
      cycles(2);

      // period 10, consumer always ready
      per_ready = 1'b1;
      pulse();
      cycles(9);
      pulse();
      chk("t1_valid", int'(per_valid), 1);
      chk("t1_data", int'(per_data), 10);
      for (int i = 0; i < 3; i++) begin
         cycles(9);
         pulse();
         chk("t1_data_n", int'(per_data), 10);
      end
      cycles(3);
      chk("t1_flags", int'({overflow, sat}), 0);

      // period 2
      do_clr();
      for (int i = 0; i < 6; i++) begin
         pulse();
         cycles(1);
         chk("t2_level_le1", int'(level <= 1), 1);
      end
      pulse();
      chk("t2_data", int'(per_data), 2);

      // backpressure until overflow, then drain
      do_clr();
      per_ready = 1'b0;
      pulse();
      for (int k = 1; k <= 5; k++) begin
         cycles(9);
         pulse();
         chk("t3_level", int'(level), (k < 4) ? k : 4);
      end
      chk("t3_overflow", int'(overflow), 1);
      per_ready = 1'b1;
      for (int k = 4; k >= 1; k--) begin
         chk("t3_pop_data", int'(per_data), 10);
         @(negedge clk);
         chk("t3_pop_level", int'(level), k - 1);
      end
      per_ready = 1'b0;

      // full FIFO with push and pop in the same edge
      do_clr();
      pulse();
      for (int k = 5; k <= 8; k++) begin
         cycles(k - 1);
         pulse();
      end
      chk("t4_full", int'(level), 4);
      chk("t4_head", int'(per_data), 5);
      cycles(8);
      y_in = 1'b1;
      per_ready = 1'b1;
      @(negedge clk);
      y_in = 1'b0;
      per_ready = 1'b0;
      chk("t4_level", int'(level), 4);
      chk("t4_ovf", int'(overflow), 0);
      chk("t4_next_head", int'(per_data), 6);

      // saturation, then clr returns to idle
      do_clr();
      pulse();
      cycles(299);
      pulse();
      chk("t5_data", int'(per_data), 255);
      chk("t5_sat", int'(sat), 1);
      do_clr();
      chk("t5_clr_level", int'(level), 0);
      chk("t5_clr_sat", int'(sat), 0);
      pulse();
      cycles(2);
      chk("t5_no_push", int'(per_valid), 0);
      cycles(7);
      pulse();
      chk("t5_rearmed", int'(per_data), 10);

      // illegal state code, sticky
      ps_in = 4'b1100;
      @(negedge clk);
      ps_in = 4'd7;
      chk("t6_err", int'(err_state), 1);
      cycles(5);
      chk("t6_err_sticky", int'(err_state), 1);

      // asynchronous reset between clock edges
      pulse();
      cycles(4);
      #2;
      rst = 1'b0;
      #1;
      chk("t7_async_valid", int'(per_valid), 0);
      chk("t7_async_level", int'(level), 0);
      chk("t7_async_flags", int'({overflow, sat, err_state}), 0);
      @(negedge clk);
      rst = 1'b1;
      pulse();
      cycles(9);
      pulse();
      chk("t7_restart_data", int'(per_data), 10);
      chk("t7_restart_level", int'(level), 1);
      cycles(3);

      run_cmp = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
